alu_op_sequencer: RTL

//  Multi-cycle operation controller for the lab ALU datapath. Accepts two

---
 rtl/alu_op_sequencer_if.sv | 24 ++
 rtl/alu_op_sequencer.sv | 139 +++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer_if.sv
// Request/response bundle between the ALU front panel and the operation sequencer.
interface alu_op_sequencer_if #(
    parameter int unsigned WIDTH = 3
);
    logic                   Start;
    logic [1:0]             Op;
    logic [WIDTH-1:0]       PortA;
    logic [WIDTH-1:0]       PortB;
    logic                   Busy;
    logic                   Done;
    logic                   Valid;
    logic                   DivZero;
    logic [2*WIDTH-1:0]     Result;

    modport master (
        output Start, Op, PortA, PortB,
        input  Busy, Done, Valid, DivZero, Result
    );

    modport slave (
        input  Start, Op, PortA, PortB,
        output Busy, Done, Valid, DivZero, Result
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Multi-cycle add/sub/mul/div controller sharing one adder/shifter; the result
// is held for the display mux until the next accepted Start edge.
module alu_op_sequencer #(
    parameter int unsigned WIDTH = 3
) (
    input logic                ClockA,
    input logic                Reset,
    alu_op_sequencer_if.slave  bus
);
    localparam int unsigned RWIDTH = 2 * WIDTH;
    localparam int unsigned CntW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

    state_e              state_q, state_d;
    logic                start_q;
    logic [1:0]          op_q, op_d;
    logic [RWIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]    b_q, b_d;
    logic [CntW-1:0]     cnt_q, cnt_d, cnt_last;
    logic [RWIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]    rem_q, rem_d;
    logic [WIDTH-1:0]    quo_q, quo_d;
    logic [RWIDTH-1:0]   result_q, result_d;
    logic                valid_q, valid_d;
    logic                divzero_q, divzero_d;
    logic [WIDTH:0]      rem_sh;
    logic [WIDTH-1:0]    quo_sh;
    logic                start_edge;

    assign start_edge = bus.Start & ~start_q;
    assign cnt_last   = op_q[1] ? CntW'(WIDTH - 1) : '0;

    always_ff @(posedge ClockA) begin
        if (Reset) begin
            state_q   <= StIdle;
            start_q   <= 1'b0;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            cnt_q     <= '0;
            acc_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            result_q  <= '0;
            valid_q   <= 1'b0;
            divzero_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            start_q   <= bus.Start;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            result_q  <= result_d;
            valid_q   <= valid_d;
            divzero_q <= divzero_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        result_d  = result_q;
        valid_d   = valid_q;
        divzero_d = divzero_q;
        rem_sh    = {rem_q, quo_q[WIDTH-1]};
        quo_sh    = quo_q << 1;

        unique case (state_q)
            StIdle: begin
                if (start_edge) begin
                    state_d   = StExec;
                    op_d      = bus.Op;
                    a_d       = RWIDTH'(bus.PortA);
                    b_d       = bus.PortB;
                    cnt_d     = '0;
                    acc_d     = '0;
                    rem_d     = '0;
                    quo_d     = bus.PortA;
                    valid_d   = 1'b0;
                    divzero_d = 1'b0;
                end
            end
            StExec: begin
                cnt_d = cnt_q + 1'b1;
                if (op_q == 2'b10) begin
                    // Shift-add, LSB of the multiplier first.
                    if (b_q[0]) acc_d = acc_q + a_q;
                    a_d = a_q << 1;
                    b_d = b_q >> 1;
                end else if (op_q == 2'b11) begin
                    if (rem_sh >= {1'b0, b_q}) begin
                        rem_sh    = rem_sh - {1'b0, b_q};
                        quo_sh[0] = 1'b1;
                    end
                    rem_d = rem_sh[WIDTH-1:0];
                    quo_d = quo_sh;
                end

                if (cnt_q == cnt_last) begin
                    state_d = StDone;
                    cnt_d   = '0;
                    valid_d = 1'b1;
                    unique case (op_q)
                        2'b00: result_d = a_q + RWIDTH'(b_q);
                        2'b01: result_d = a_q - RWIDTH'(b_q);
                        2'b10: result_d = acc_d;
                        2'b11: begin
                            if (b_q == '0) begin
                                result_d  = {a_q[WIDTH-1:0], {WIDTH{1'b1}}};
                                divzero_d = 1'b1;
                            end else begin
                                result_d = {rem_sh[WIDTH-1:0], quo_sh};
                            end
                        end
                    endcase
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign bus.Busy    = (state_q == StExec);
    assign bus.Done    = (state_q == StDone);
    assign bus.Valid   = valid_q;
    assign bus.DivZero = divzero_q;
    assign bus.Result  = result_q;
endmodule
